// File: rtl/exec_pkg.sv
// Shared types and constants for the execute stage: operand widths, ALU opcodes, FSM states.
package exec_pkg;
  localparam int DEF_DATA_W = 24;
  localparam int DEF_REG_W  = 4;
  localparam int MUL_ITERS  = 24;

  typedef enum logic [2:0] {
    OP_ADD = 3'd0,
    OP_SUB = 3'd1,
    OP_AND = 3'd2,
    OP_OR  = 3'd3,
    OP_XOR = 3'd4,
    OP_SLL = 3'd5,
    OP_SRL = 3'd6,
    OP_MUL = 3'd7
  } alu_op_t;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } exec_state_t;
endpackage

// File: rtl/iter_mul.sv
// Shift-add multiplier, one partial product per cycle; only built when EXEC_MUL_EN is defined.
// product is combinational and already includes the current step, so it is complete in the done cycle.
`ifdef EXEC_MUL_EN
module iter_mul
  import exec_pkg::*;
#(
  parameter int W = DEF_DATA_W
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         start,
  input  logic         abort,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic         done,
  output logic [W-1:0] product
);
  logic         busy;
  logic [4:0]   iter;
  logic [W-1:0] acc;
  logic [W-1:0] mcand;
  logic [W-1:0] mplier;

  assign product = acc + (mplier[0] ? mcand : '0);
  assign done    = busy && (iter == 5'(MUL_ITERS - 1));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      busy   <= 1'b0;
      iter   <= '0;
      acc    <= '0;
      mcand  <= '0;
      mplier <= '0;
    end else if (abort) begin
      busy <= 1'b0;
      iter <= '0;
    end else if (start) begin
      busy   <= 1'b1;
      iter   <= '0;
      acc    <= '0;
      mcand  <= a;
      mplier <= b;
    end else if (busy) begin
      acc    <= product;
      mcand  <= mcand << 1;
      mplier <= mplier >> 1;
      iter   <= iter + 5'd1;
      if (done) busy <= 1'b0;
    end
  end
endmodule
`endif

// File: rtl/execute_stage.sv
// Execute stage: single-cycle ALU into a registered memory-stage boundary; 1-cycle latency.
// EXEC_MUL_EN adds an iterative MUL (25-cycle latency) that holds decode via combinational stall.
module execute_stage
  import exec_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int REG_W  = DEF_REG_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              inValid,
  input  logic [2:0]        aluOp,
  input  logic [DATA_W-1:0] srcA,
  input  logic [DATA_W-1:0] srcB,
  input  logic [DATA_W-1:0] storeData,
  input  logic              memWeIn,
  input  logic              writeRegFromAluIn,
  input  logic              regWeIn,
  input  logic [REG_W-1:0]  regToWriteIn,
  input  logic              flush,
  output logic              stall,
  output logic              memWe,
  output logic              writeRegFromAlu,
  output logic              regWe,
  output logic [DATA_W-1:0] result,
  output logic [DATA_W-1:0] dataToWrite,
  output logic [REG_W-1:0]  regToWrite
);
  logic [4:0]        shamt;
  logic [DATA_W-1:0] alu_res;
  logic              load_new;
  logic              nxt_mwe, nxt_wrf, nxt_rwe;
  logic [DATA_W-1:0] nxt_res, nxt_dtw;
  logic [REG_W-1:0]  nxt_rtw;

  assign shamt = srcB[4:0];

  always_comb begin
    alu_res = '0;
    case (alu_op_t'(aluOp))
      OP_ADD:  alu_res = srcA + srcB;
      OP_SUB:  alu_res = srcA - srcB;
      OP_AND:  alu_res = srcA & srcB;
      OP_OR:   alu_res = srcA | srcB;
      OP_XOR:  alu_res = srcA ^ srcB;
      OP_SLL:  if (int'(shamt) < DATA_W) alu_res = srcA << shamt;
      OP_SRL:  if (int'(shamt) < DATA_W) alu_res = srcA >> shamt;
      default: alu_res = '0;
    endcase
  end

`ifdef EXEC_MUL_EN
  localparam logic [4:0] LAST = 5'(MUL_ITERS - 1);

  exec_state_t       state;
  logic [4:0]        count;
  logic              lat_mwe, lat_wrf, lat_rwe;
  logic [DATA_W-1:0] lat_dtw;
  logic [REG_W-1:0]  lat_rtw;
  logic              is_mul, mul_start, mul_done;
  logic [DATA_W-1:0] mul_product;

  assign is_mul    = (alu_op_t'(aluOp) == OP_MUL);
  assign mul_start = !flush && (state == ST_IDLE) && inValid && is_mul;
  assign load_new  = !flush && (state == ST_IDLE) && inValid && !is_mul;
  // Released in the final iteration so decode's held MUL is accepted on the same edge as the product.
  assign stall = reset && (mul_start || (!flush && (state == ST_BUSY) && (count != LAST)));

  iter_mul #(.W(DATA_W)) u_iter_mul (
    .clk     (clk),
    .reset   (reset),
    .start   (mul_start),
    .abort   (flush),
    .a       (srcA),
    .b       (srcB),
    .done    (mul_done),
    .product (mul_product)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state   <= ST_IDLE;
      count   <= '0;
      lat_mwe <= 1'b0;
      lat_wrf <= 1'b0;
      lat_rwe <= 1'b0;
      lat_dtw <= '0;
      lat_rtw <= '0;
    end else if (flush) begin
      state <= ST_IDLE;
      count <= '0;
    end else if (mul_start) begin
      state   <= ST_BUSY;
      count   <= '0;
      lat_mwe <= memWeIn;
      lat_wrf <= writeRegFromAluIn;
      lat_rwe <= regWeIn;
      lat_dtw <= storeData;
      lat_rtw <= regToWriteIn;
    end else if (state == ST_BUSY) begin
      if (count == LAST) begin
        state <= ST_IDLE;
        count <= '0;
      end else begin
        count <= count + 5'd1;
      end
    end
  end
`else
  assign stall    = 1'b0;
  assign load_new = !flush && inValid;
`endif

  always_comb begin
    nxt_mwe = 1'b0;
    nxt_wrf = 1'b0;
    nxt_rwe = 1'b0;
    nxt_res = '0;
    nxt_dtw = '0;
    nxt_rtw = '0;
    if (load_new) begin
      nxt_mwe = memWeIn;
      nxt_wrf = writeRegFromAluIn;
      nxt_rwe = regWeIn;
      nxt_res = alu_res;
      nxt_dtw = storeData;
      nxt_rtw = regToWriteIn;
    end
`ifdef EXEC_MUL_EN
    else if (mul_done && !flush) begin
      nxt_mwe = lat_mwe;
      nxt_wrf = lat_wrf;
      nxt_rwe = lat_rwe;
      nxt_res = mul_product;
      nxt_dtw = lat_dtw;
      nxt_rtw = lat_rtw;
    end
`endif
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      memWe           <= 1'b0;
      writeRegFromAlu <= 1'b0;
      regWe           <= 1'b0;
      result          <= '0;
      dataToWrite     <= '0;
      regToWrite      <= '0;
    end else begin
      memWe           <= nxt_mwe;
      writeRegFromAlu <= nxt_wrf;
      regWe           <= nxt_rwe;
      result          <= nxt_res;
      dataToWrite     <= nxt_dtw;
      regToWrite      <= nxt_rtw;
    end
  end
endmodule

// File: tb/tb_execute_stage.sv
// Bench for execute_stage: vector table, directed reset/MUL/flush sequences, random ops vs arithmetic model.
module tb_execute_stage;
  logic        clk = 1'b0;
  logic        reset;
  logic        inValid;
  logic [2:0]  aluOp;
  logic [23:0] srcA, srcB, storeData;
  logic        memWeIn, writeRegFromAluIn, regWeIn;
  logic [3:0]  regToWriteIn;
  logic        flush;
  logic        stall, memWe, writeRegFromAlu, regWe;
  logic [23:0] result, dataToWrite;
  logic [3:0]  regToWrite;

  int total = 0;
  int bad   = 0;

  execute_stage #(.DATA_W(24), .REG_W(4)) dut (
    .clk(clk), .reset(reset), .inValid(inValid), .aluOp(aluOp),
    .srcA(srcA), .srcB(srcB), .storeData(storeData),
    .memWeIn(memWeIn), .writeRegFromAluIn(writeRegFromAluIn), .regWeIn(regWeIn),
    .regToWriteIn(regToWriteIn), .flush(flush), .stall(stall),
    .memWe(memWe), .writeRegFromAlu(writeRegFromAlu), .regWe(regWe),
    .result(result), .dataToWrite(dataToWrite), .regToWrite(regToWrite)
  );

  always #5 clk = ~clk;

  logic [54:0] outs;
  assign outs = {memWe, writeRegFromAlu, regWe, result, dataToWrite, regToWrite};

  function automatic logic [54:0] pk(input logic [2:0] ctl, input logic [23:0] res,
                                     input logic [23:0] dtw, input logic [3:0] rtw);
    return {ctl, res, dtw, rtw};
  endfunction

  // Architectural meaning of each op, in plain integer arithmetic.
  function automatic logic [23:0] ref_alu(input int op, input logic [23:0] a, input logic [23:0] b);
    longint unsigned ua = 64'(a);
    longint unsigned ub = 64'(b);
    longint unsigned m  = 64'd1 << 24;
    longint unsigned p  = 64'd1 << b[4:0];
    longint unsigned r  = 0;
    case (op)
      0: r = (ua + ub) % m;
      1: r = (ua + m - ub) % m;
      2: r = ua & ub;
      3: r = ua | ub;
      4: r = ua ^ ub;
      5: r = (b[4:0] >= 5'd24) ? 64'd0 : (ua * p) % m;
      6: r = ua / p;
`ifdef EXEC_MUL_EN
      default: r = (ua * ub) % m;
`else
      default: r = 0;
`endif
    endcase
    return r[23:0];
  endfunction

  task automatic chk(input string nm, input logic [54:0] got, input logic [54:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h want=%h", nm, got, exp);
    end
  endtask

  task automatic chk_stall(input string nm, input logic exp);
    total++;
    if (stall !== exp) begin
      bad++;
      $display("FAIL %s: stall got=%b want=%b", nm, stall, exp);
    end
  endtask

  task automatic drive(input logic v, input logic [2:0] op, input logic [23:0] a, input logic [23:0] b,
                       input logic [23:0] sd, input logic [2:0] ctl, input logic [3:0] rd, input logic fl);
    inValid = v; aluOp = op; srcA = a; srcB = b; storeData = sd;
    {memWeIn, writeRegFromAluIn, regWeIn} = ctl;
    regToWriteIn = rd; flush = fl;
  endtask

`ifdef EXEC_MUL_EN
  // Caller has just driven a MUL (#1 after an edge); flush_at<0 means run to completion.
  task automatic run_mul(input string nm, input int flush_at);
    logic [54:0] exp_o;
    exp_o = pk({memWeIn, writeRegFromAluIn, regWeIn}, ref_alu(7, srcA, srcB), storeData, regToWriteIn);
    for (int c = 0; c <= 24; c++) begin
      flush = (c == flush_at);
      #1;
      chk_stall($sformatf("%s_stall_c%0d", nm, c), (c == flush_at) ? 1'b0 : (c < 24));
      @(posedge clk); #1;
      if (c == flush_at) begin
        flush = 1'b0;
        inValid = 1'b0;
        chk($sformatf("%s_flush_bubble", nm), outs, '0);
        return;
      end
      if (c < 24) chk($sformatf("%s_busy_bubble_c%0d", nm, c + 1), outs, '0);
    end
    chk($sformatf("%s_product", nm), outs, exp_o);
  endtask
`endif

  typedef struct {
    logic [2:0]  op;
    logic [23:0] a, b, sd;
    logic [2:0]  ctl;
    logic [3:0]  rd;
    logic [23:0] exp_res;
  } vec_t;

  vec_t vecs[$];

  initial begin
    vecs.push_back('{3'd0, 24'hFFFFFF, 24'h000002, 24'h000011, 3'b001, 4'd5, 24'h000001});
    vecs.push_back('{3'd1, 24'h000003, 24'h000005, 24'h000022, 3'b001, 4'd6, 24'hFFFFFE});
    vecs.push_back('{3'd5, 24'h000001, 24'd23,     24'h000033, 3'b011, 4'd1, 24'h800000});
    vecs.push_back('{3'd6, 24'h800000, 24'd24,     24'h000044, 3'b001, 4'd2, 24'h000000});
    vecs.push_back('{3'd5, 24'hFFFFFF, 24'd31,     24'h000055, 3'b100, 4'd3, 24'h000000});
    vecs.push_back('{3'd6, 24'h800000, 24'd23,     24'h000066, 3'b010, 4'd4, 24'h000001});
    vecs.push_back('{3'd5, 24'h000ABC, 24'h000104, 24'h000077, 3'b001, 4'd7, 24'h00ABC0});
    vecs.push_back('{3'd2, 24'hF0F0F0, 24'h0FF0FF, 24'h000088, 3'b111, 4'd8, 24'h00F0F0});
    vecs.push_back('{3'd3, 24'hF00000, 24'h00000F, 24'h000099, 3'b001, 4'd9, 24'hF0000F});
    vecs.push_back('{3'd4, 24'hFFFF00, 24'h0F0F0F, 24'h0000AA, 3'b001, 4'd10, 24'hF0F00F});
`ifndef EXEC_MUL_EN
    vecs.push_back('{3'd7, 24'h000003, 24'h000004, 24'h0000BB, 3'b001, 4'd11, 24'h000000});
`endif

    reset = 1'b0;
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    repeat (2) @(posedge clk);
    #1;
    chk("reset_outs", outs, '0);
    chk_stall("reset_stall", 1'b0);
    #3 reset = 1'b1;
    @(posedge clk); #1;
    chk("idle_bubble", outs, '0);

    // Back-to-back vector table, one instruction per cycle.
    for (int i = 0; i < vecs.size(); i++) begin
      drive(1, vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].sd, vecs[i].ctl, vecs[i].rd, 0);
      #1 chk_stall($sformatf("vec%0d_stall", i), 1'b0);
      @(posedge clk); #1;
      chk($sformatf("vec%0d", i), outs, pk(vecs[i].ctl, vecs[i].exp_res, vecs[i].sd, vecs[i].rd));
    end

    // Reset pulled low between edges with a live result on the outputs.
    drive(1, 0, 24'h000100, 24'h000023, 24'h00ABCD, 3'b111, 4'd3, 0);
    @(posedge clk); #1;
    chk("pre_reset_add", outs, pk(3'b111, 24'h000123, 24'h00ABCD, 4'd3));
    #2 reset = 1'b0;
    #1;
    chk("midstream_reset_outs", outs, '0);
    chk_stall("midstream_reset_stall", 1'b0);
    drive(0, 0, 24'h000100, 24'h000023, 24'h00ABCD, 3'b111, 4'd3, 0);
    #2 reset = 1'b1;
    @(posedge clk); #1;
    chk("post_reset_bubble", outs, '0);

`ifdef EXEC_MUL_EN
    begin
      int seen;
      drive(1, 7, 24'h001000, 24'h000300, 24'h0000AA, 3'b001, 4'd7, 0);
      run_mul("mul_basic", -1);
      drive(1, 0, 24'h000002, 24'h000003, 24'h0000BB, 3'b001, 4'd1, 0);
      #1 chk_stall("add_after_mul_stall", 1'b0);
      @(posedge clk); #1;
      chk("add_after_mul", outs, pk(3'b001, 24'h000005, 24'h0000BB, 4'd1));

      drive(1, 7, 24'h000005, 24'h000007, 24'h0000CC, 3'b101, 4'd9, 0);
      run_mul("mul_flush", 10);
      seen = 0;
      for (int c = 0; c < 30; c++) begin
        @(posedge clk); #1;
        if (outs !== '0) seen++;
      end
      chk("no_product_after_flush", 55'(seen), '0);
      drive(1, 0, 24'h000010, 24'h000020, 24'h0000DD, 3'b001, 4'd2, 0);
      @(posedge clk); #1;
      chk("add_after_flush", outs, pk(3'b001, 24'h000030, 24'h0000DD, 4'd2));
    end
`endif

    // Random instructions, flushes and bubbles against the arithmetic model.
    for (int n = 0; n < 150; n++) begin
      logic        v, fl;
      logic [2:0]  op, ctl;
      logic [23:0] a, b, sd;
      logic [3:0]  rd;
      v   = ($urandom % 4) != 0;
      fl  = ($urandom % 8) == 0;
      op  = 3'($urandom_range(0, 7));
      a   = 24'($urandom);
      b   = ($urandom % 2) ? 24'($urandom_range(0, 40)) : 24'($urandom);
      sd  = 24'($urandom);
      ctl = 3'($urandom);
      rd  = 4'($urandom);
`ifdef EXEC_MUL_EN
      if (op == 3'd7 && v && !fl) begin
        drive(1, op, a, b, sd, ctl, rd, 0);
        run_mul($sformatf("rnd%0d_mul", n), (($urandom % 4) == 0) ? int'($urandom_range(0, 24)) : -1);
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        continue;
      end
`endif
      drive(v, op, a, b, sd, ctl, rd, fl);
      #1 chk_stall($sformatf("rnd%0d_stall", n), 1'b0);
      @(posedge clk); #1;
      chk($sformatf("rnd%0d", n), outs, (v && !fl) ? pk(ctl, ref_alu(int'(op), a, b), sd, rd) : 55'd0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
